// File: rtl/jtkunio_layer_mix_pkg.sv
// Shared constants for the Kunio layer mixer: colour byte layout, default
// transparency mask and pipeline latency.
package jtkunio_layer_mix_pkg;

  localparam int MIX_LAT = 4;
  localparam logic [5:0] TMASK_DEF = 6'h0F;

  // Byte 0 holds {G,B}; byte 1 holds R in its low nibble.
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;
  localparam int R_LSB = 0;

  function automatic logic [3:0] nib(input logic [7:0] b, input int lsb);
    nib = b[lsb +: 4];
  endfunction

endpackage

// File: rtl/jtkunio_layer_mix_if.sv
// CPU palette access port of the layer mixer.
interface jtkunio_layer_mix_if #(
  parameter int PALW = 8
);
  logic            pal_cs;
  logic            cpu_wrn;
  logic [PALW:0]   cpu_addr;
  logic [7:0]      cpu_dout;
  logic [7:0]      pal_dout;

  modport master (output pal_cs, cpu_wrn, cpu_addr, cpu_dout, input pal_dout);
  modport slave  (input pal_cs, cpu_wrn, cpu_addr, cpu_dout, output pal_dout);
endinterface

// File: rtl/jtframe_dual_ram.sv
// Single-clock dual-port RAM: port 0 read/write, port 1 read-only.
// Reads are registered and return old data on a same-address write.
module jtframe_dual_ram #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] data0,
  output logic [DW-1:0] q0,
  input  logic          cen1,
  input  logic [AW-1:0] addr1,
  output logic [DW-1:0] q1
);
  logic [DW-1:0] r_mem [0:2**AW-1];

  always_ff @(posedge clk) begin
    if (we0) r_mem[addr0] <= data0;
  end

  // Only the output registers reset; the array contents survive rst.
  always_ff @(posedge clk) begin
    if (rst)       q0 <= '0;
    else if (cen0) q0 <= r_mem[addr0];
  end

  always_ff @(posedge clk) begin
    if (rst)       q1 <= '0;
    else if (cen1) q1 <= r_mem[addr1];
  end
endmodule

// File: rtl/jtkunio_layer_prio.sv
// Priority resolver: picks the first opaque, enabled layer in slot order and
// registers its palette address.
module jtkunio_layer_prio import jtkunio_layer_mix_pkg::*; #(
  parameter int LAYERS = 4,
  parameter int PXLW = 6,
  parameter int LIW = 2,
  parameter logic [PXLW-1:0] TMASK = PXLW'(TMASK_DEF),
  parameter int BACKDROP = 0,
  localparam int PALW = LIW + PXLW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic [LAYERS*PXLW-1:0] pxl,
  input  logic [LAYERS*LIW-1:0]  prio,
  input  logic [LAYERS-1:0]      gfx_en,
  output logic [PALW-1:0]        addr
);
  logic [LAYERS-1:0] w_opaque;
  logic [PALW-1:0]   w_addr;

  for (genvar gi = 0; gi < LAYERS; gi++) begin : g_opaque
    assign w_opaque[gi] = gfx_en[gi] && ((pxl[gi*PXLW +: PXLW] & TMASK) != '0);
  end

  // Indices beyond LAYERS never win; repeated indices resolve at first use.
  always_comb begin
    logic [LIW-1:0] idx;
    logic           hit;
    w_addr = PALW'(BACKDROP);
    hit    = 1'b0;
    idx    = '0;
    for (int s = 0; s < LAYERS; s++) begin
      idx = prio[s*LIW +: LIW];
      if (!hit && (int'(idx) < LAYERS) && w_opaque[idx]) begin
        hit    = 1'b1;
        w_addr = {idx, pxl[int'(idx)*PXLW +: PXLW]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      addr <= '0;
    else if (cen) addr <= w_addr;
  end
endmodule

// File: rtl/jtkunio_layer_mix.sv
// N-layer colour mixer: programmable priority, per-layer transparency and
// masking, CPU palette, blanking-gated RGB with matched blanking delay.
module jtkunio_layer_mix import jtkunio_layer_mix_pkg::*; #(
  parameter int LAYERS = 4,
  parameter int PXLW = 6,
  parameter int LIW = 2,
  parameter logic [PXLW-1:0] TMASK = PXLW'(TMASK_DEF),
  parameter int BACKDROP = 0,
  localparam int PALW = LIW + PXLW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pxl_cen,
  input  logic                   LHBL,
  input  logic                   LVBL,
  input  logic [LAYERS*PXLW-1:0] layer_pxl,
  input  logic [LAYERS*LIW-1:0]  prio,
  input  logic [LAYERS-1:0]      gfx_en,
  jtkunio_layer_mix_if.slave     cpu,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic                   LHBL_dly,
  output logic                   LVBL_dly
);
  logic [LAYERS*PXLW-1:0] r_pxl;
  logic [LAYERS*LIW-1:0]  r_prio;
  logic [LAYERS-1:0]      r_gfx_en;
  // Blanking shift for S1..S3; S4 is the output register itself.
  logic [MIX_LAT-2:0]     r_hb, r_vb;
  logic                   r_bsel;
  logic [PALW-1:0]        w_vaddr;
  logic [7:0]             w_cpu_lo, w_cpu_hi, w_vid_lo, w_vid_hi;
  logic                   w_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pxl    <= '0;
      r_prio   <= '0;
      r_gfx_en <= '0;
      r_hb     <= '0;
      r_vb     <= '0;
    end else if (pxl_cen) begin
      r_pxl    <= layer_pxl;
      r_prio   <= prio;
      r_gfx_en <= gfx_en;
      r_hb     <= {r_hb[MIX_LAT-3:0], LHBL};
      r_vb     <= {r_vb[MIX_LAT-3:0], LVBL};
    end
  end

  jtkunio_layer_prio #(
    .LAYERS  (LAYERS),
    .PXLW    (PXLW),
    .LIW     (LIW),
    .TMASK   (TMASK),
    .BACKDROP(BACKDROP)
  ) u_prio (
    .clk   (clk),
    .rst   (rst),
    .cen   (pxl_cen),
    .pxl   (r_pxl),
    .prio  (r_prio),
    .gfx_en(r_gfx_en),
    .addr  (w_vaddr)
  );

  assign w_we = cpu.pal_cs & ~cpu.cpu_wrn;

  jtframe_dual_ram #(.DW(8), .AW(PALW)) u_pal_lo (
    .clk  (clk),
    .rst  (rst),
    .cen0 (cpu.pal_cs),
    .we0  (w_we & ~cpu.cpu_addr[0]),
    .addr0(cpu.cpu_addr[PALW:1]),
    .data0(cpu.cpu_dout),
    .q0   (w_cpu_lo),
    .cen1 (pxl_cen),
    .addr1(w_vaddr),
    .q1   (w_vid_lo)
  );

  jtframe_dual_ram #(.DW(8), .AW(PALW)) u_pal_hi (
    .clk  (clk),
    .rst  (rst),
    .cen0 (cpu.pal_cs),
    .we0  (w_we & cpu.cpu_addr[0]),
    .addr0(cpu.cpu_addr[PALW:1]),
    .data0(cpu.cpu_dout),
    .q0   (w_cpu_hi),
    .cen1 (pxl_cen),
    .addr1(w_vaddr),
    .q1   (w_vid_hi)
  );

  // Byte select is latched with the address so pal_dout holds while deselected.
  always_ff @(posedge clk) begin
    if (rst)             r_bsel <= 1'b0;
    else if (cpu.pal_cs) r_bsel <= cpu.cpu_addr[0];
  end

  assign cpu.pal_dout = r_bsel ? w_cpu_hi : w_cpu_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      red      <= '0;
      green    <= '0;
      blue     <= '0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      LHBL_dly <= r_hb[MIX_LAT-2];
      LVBL_dly <= r_vb[MIX_LAT-2];
      if (r_hb[MIX_LAT-2] && r_vb[MIX_LAT-2]) begin
        red   <= nib(w_vid_hi, R_LSB);
        green <= nib(w_vid_lo, G_LSB);
        blue  <= nib(w_vid_lo, B_LSB);
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_jtkunio_layer_mix.sv
// Directed bench for jtkunio_layer_mix: reset, palette access, priority,
// backdrop, blanking alignment, collision and stall.
module tb_jtkunio_layer_mix;
  import jtkunio_layer_mix_pkg::*;

  localparam int LAYERS = 4;
  localparam int PXLW   = 6;
  localparam int LIW    = 2;
  localparam int PALW   = LIW + PXLW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pxl_cen = 1'b0;
  logic LHBL = 1'b1;
  logic LVBL = 1'b1;
  logic [LAYERS*PXLW-1:0] layer_pxl = '0;
  logic [LAYERS*LIW-1:0]  prio = 8'hE4;
  logic [LAYERS-1:0]      gfx_en = 4'hF;
  logic [3:0] red, green, blue;
  logic LHBL_dly, LVBL_dly;

  int checks = 0;
  int passed = 0;

  jtkunio_layer_mix_if #(.PALW(PALW)) cpu_if ();

  always #5 clk = ~clk;

  jtkunio_layer_mix #(
    .LAYERS  (LAYERS),
    .PXLW    (PXLW),
    .LIW     (LIW),
    .TMASK   (6'h0F),
    .BACKDROP(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .layer_pxl(layer_pxl),
    .prio     (prio),
    .gfx_en   (gfx_en),
    .cpu      (cpu_if),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  // One pixel step: a single pxl_cen clock followed by an idle clock.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      pxl_cen = 1'b1;
      @(posedge clk); #1;
      pxl_cen = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic cpu_wr(input logic [PALW:0] a, input logic [7:0] d);
    cpu_if.pal_cs   = 1'b1;
    cpu_if.cpu_wrn  = 1'b0;
    cpu_if.cpu_addr = a;
    cpu_if.cpu_dout = d;
    @(posedge clk); #1;
    cpu_if.pal_cs   = 1'b0;
    cpu_if.cpu_wrn  = 1'b1;
  endtask

  task automatic cpu_rd(input logic [PALW:0] a, output logic [7:0] d);
    cpu_if.pal_cs   = 1'b1;
    cpu_if.cpu_wrn  = 1'b1;
    cpu_if.cpu_addr = a;
    @(posedge clk); #1;
    d = cpu_if.pal_dout;
    cpu_if.pal_cs   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks++;
    if ({red, green, blue} !== 12'h000) $display("FAIL reset_rgb: got %h want 000", {red, green, blue});
    else passed++;
    checks++;
    if ({LHBL_dly, LVBL_dly} !== 2'b00) $display("FAIL reset_blank: got %b want 00", {LHBL_dly, LVBL_dly});
    else passed++;
    checks++;
    if (cpu_if.pal_dout !== 8'h00) $display("FAIL reset_pal_dout: got %h want 00", cpu_if.pal_dout);
    else passed++;
    rst = 1'b0;
    $display("reset: rgb=%h blank=%b", {red, green, blue}, {LHBL_dly, LVBL_dly});
  endtask

  task automatic test_palette();
    logic [7:0] d;
    cpu_wr(9'h000, 8'h21);
    cpu_wr(9'h001, 8'h04);
    cpu_wr(9'h08A, 8'h3C);
    cpu_wr(9'h08B, 8'h07);
    cpu_rd(9'h08A, d);
    checks++;
    if (d !== 8'h3C) $display("FAIL pal_read_lo: got %h want 3C", d);
    else passed++;
    cpu_rd(9'h08B, d);
    checks++;
    if (d !== 8'h07) $display("FAIL pal_read_hi: got %h want 07", d);
    else passed++;
    cpu_if.cpu_addr = 9'h08A;
    @(posedge clk); #1;
    checks++;
    if (cpu_if.pal_dout !== 8'h07) $display("FAIL pal_hold: got %h want 07", cpu_if.pal_dout);
    else passed++;
    layer_pxl = '0;
    step(4);
    checks++;
    if ({red, green, blue} !== 12'h421) $display("FAIL backdrop_initial: got %h want 421", {red, green, blue});
    else passed++;
    layer_pxl = 24'h000140;
    step(3);
    checks++;
    if ({red, green, blue} !== 12'h421) $display("FAIL latency_early: got %h want 421", {red, green, blue});
    else passed++;
    step(1);
    checks++;
    if ({red, green, blue} !== 12'h73C) $display("FAIL layer1_colour: got %h want 73C", {red, green, blue});
    else passed++;
    $display("palette: rgb=%h", {red, green, blue});
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    step(1);
    checks++;
    if ({red, green, blue, LHBL_dly, LVBL_dly, cpu_if.pal_dout} !== 22'h0)
      $display("FAIL midreset_outputs: got %h %b %h want 000 00 00",
               {red, green, blue}, {LHBL_dly, LVBL_dly}, cpu_if.pal_dout);
    else passed++;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if ({red, green, blue, LHBL_dly} !== 13'h0)
        $display("FAIL midreset_hold%0d: got %h %b want 000 0", i, {red, green, blue}, LHBL_dly);
      else passed++;
    end
    step(1);
    checks++;
    if ({red, green, blue, LHBL_dly, LVBL_dly} !== {12'h73C, 2'b11})
      $display("FAIL midreset_first: got %h %b want 73C 11", {red, green, blue}, {LHBL_dly, LVBL_dly});
    else passed++;
    $display("reset_mid: rgb=%h", {red, green, blue});
  endtask

  task automatic test_priority();
    cpu_wr(9'h122, 8'hA5);
    cpu_wr(9'h123, 8'h0B);
    cpu_wr(9'h022, 8'h12);
    cpu_wr(9'h023, 8'h03);
    layer_pxl = {6'h00, 6'h11, 6'h00, 6'h11};
    prio      = 8'hD2;
    step(4);
    checks++;
    if ({red, green, blue} !== 12'hBA5) $display("FAIL prio_layer2: got %h want BA5", {red, green, blue});
    else passed++;
    gfx_en = 4'b1011;
    step(3);
    checks++;
    if ({red, green, blue} !== 12'hBA5) $display("FAIL prio_no_glitch: got %h want BA5", {red, green, blue});
    else passed++;
    step(1);
    checks++;
    if ({red, green, blue} !== 12'h312) $display("FAIL prio_masked: got %h want 312", {red, green, blue});
    else passed++;
    prio = 8'hAA;
    step(4);
    checks++;
    if ({red, green, blue} !== 12'h421) $display("FAIL prio_dup_masked: got %h want 421", {red, green, blue});
    else passed++;
    gfx_en = 4'hF;
    prio   = 8'hE4;
    $display("priority: rgb=%h", {red, green, blue});
  endtask

  task automatic test_backdrop();
    cpu_wr(9'h000, 8'hFF);
    cpu_wr(9'h001, 8'h0F);
    layer_pxl = {4{6'h30}};
    step(4);
    checks++;
    if ({red, green, blue} !== 12'hFFF) $display("FAIL backdrop_white: got %h want FFF", {red, green, blue});
    else passed++;
    $display("backdrop: rgb=%h", {red, green, blue});
  endtask

  task automatic test_blanking();
    int lows;
    logic exp;
    lows = 0;
    for (int i = 0; i < 28; i++) begin
      LHBL = !(i >= 2 && i < 18);
      step(1);
      exp = ((i - 3) < 2) || ((i - 3) >= 18);
      if (!LHBL_dly) lows++;
      checks++;
      if ({LHBL_dly, LVBL_dly, red, green, blue} !== {exp, 1'b1, exp ? 12'hFFF : 12'h000})
        $display("FAIL blank_step%0d: got %b%b %h want %b1 %h", i, LHBL_dly, LVBL_dly,
                 {red, green, blue}, exp, exp ? 12'hFFF : 12'h000);
      else passed++;
    end
    checks++;
    if (lows !== 16) $display("FAIL blank_width: got %0d want 16", lows);
    else passed++;
    LHBL = 1'b1;
    $display("blanking: low pixels=%0d", lows);
  endtask

  task automatic test_collision();
    pxl_cen         = 1'b1;
    cpu_if.pal_cs   = 1'b1;
    cpu_if.cpu_wrn  = 1'b0;
    cpu_if.cpu_addr = 9'h000;
    cpu_if.cpu_dout = 8'h00;
    @(posedge clk); #1;
    pxl_cen        = 1'b0;
    cpu_if.pal_cs  = 1'b0;
    cpu_if.cpu_wrn = 1'b1;
    @(posedge clk); #1;
    step(1);
    checks++;
    if ({red, green, blue} !== 12'hFFF) $display("FAIL collision_old: got %h want FFF", {red, green, blue});
    else passed++;
    step(1);
    checks++;
    if ({red, green, blue} !== 12'hF00) $display("FAIL collision_new: got %h want F00", {red, green, blue});
    else passed++;
    $display("collision: rgb=%h", {red, green, blue});
  endtask

  task automatic test_stall();
    logic [7:0] d;
    int bad;
    bad = 0;
    layer_pxl = {6'h00, 6'h00, 6'h00, 6'h11};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ({red, green, blue} !== 12'hF00) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL stall_hold: got %0d changed clocks want 0 (rgb %h)", bad, {red, green, blue});
    else passed++;
    cpu_wr(9'h001, 8'hAF);
    cpu_rd(9'h001, d);
    checks++;
    if (d !== 8'hAF) $display("FAIL stall_cpu_read: got %h want AF", d);
    else passed++;
    checks++;
    if ({red, green, blue} !== 12'hF00) $display("FAIL stall_after_cpu: got %h want F00", {red, green, blue});
    else passed++;
    step(4);
    checks++;
    if ({red, green, blue} !== 12'h312) $display("FAIL stall_resume: got %h want 312", {red, green, blue});
    else passed++;
    layer_pxl = {4{6'h30}};
    step(4);
    checks++;
    if ({red, green, blue} !== 12'hF00) $display("FAIL r_high_nibble: got %h want F00", {red, green, blue});
    else passed++;
    $display("stall: rgb=%h readback=%h", {red, green, blue}, d);
  endtask

  initial begin
    cpu_if.pal_cs   = 1'b0;
    cpu_if.cpu_wrn  = 1'b1;
    cpu_if.cpu_addr = '0;
    cpu_if.cpu_dout = '0;
    test_reset();
    test_palette();
    test_reset_mid();
    test_priority();
    test_backdrop();
    test_blanking();
    test_collision();
    test_stall();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
